ysyx_axi_arb_fsm: RTL

YSYX_AXI_ARB_FSM -- requirements
Module: ysyx_axi_arb_fsm

---
 rtl/ysyx_axi_arb_fsm_pkg.sv | 35 +++
 rtl/ysyx_axi_arb_fsm_lane_align.sv | 26 ++
 rtl/ysyx_axi_arb_fsm.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_axi_arb_fsm_pkg.sv
// Shared definitions for the AXI arbiter: FSM state and owner encodings,
// fixed AXI4 field values and the byte-mask to AXI size mapping.
package ysyx_axi_arb_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    localparam logic [2:0] AXI_SIZE_1B   = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B   = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B   = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [3:0] AXI_ID_ZERO    = 4'd0;

    // Only byte, halfword and word masks are legal; anything else is treated as a word.
    function automatic logic [2:0] mask_to_size(input logic [3:0] mask);
        case (mask)
            4'h1:    return AXI_SIZE_1B;
            4'h3:    return AXI_SIZE_2B;
            default: return AXI_SIZE_4B;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_axi_arb_fsm_lane_align.sv
// Byte-lane steering between the 32-bit requester side and the 64-bit AXI bus.
module ysyx_axi_lane_align (
    input  logic [63:0] rdata,
    input  logic [2:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [3:0]  mask,
    output logic [31:0] rword,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb
);

    logic [31:0] rd_lane;
    logic [31:0] wr_shift;
    logic [3:0]  strb4;

    // Pick the 32-bit half, right-align reads, left-shift and replicate writes.
    always_comb begin
        rd_lane  = addr_lo[2] ? rdata[63:32] : rdata[31:0];
        rword    = rd_lane >> {addr_lo[1:0], 3'b000};
        wr_shift = word << {addr_lo[1:0], 3'b000};
        wdata    = {wr_shift, wr_shift};
        strb4    = mask << addr_lo[1:0];
        wstrb    = addr_lo[2] ? {strb4, 4'h0} : {4'h0, strb4};
    end

endmodule

// File: rtl/ysyx_axi_arb_fsm.sv
// Single-outstanding AXI4 arbiter for IFU fetches, LSU loads and LSU stores.
//
// state | meaning
// IDLE  | no transaction; arbitrate store > load > fetch (IFU first when flagged)
// AR    | read address presented, waiting for arready
// R     | waiting for the single read beat
// AW_W  | write address and data presented, each retired on its own handshake
// B     | waiting for the write response
module ysyx_axi_arb_fsm
    import ysyx_axi_arb_fsm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_arvalid,
    input  logic [ADDR_W-1:0] ifu_araddr,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_rvalid_o,

    input  logic              lsu_arvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_rvalid_o,

    input  logic              lsu_awvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    output logic              lsu_bvalid_o,

    input  logic              io_master_arready,
    output logic              io_master_arvalid,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [3:0]        io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,

    output logic              io_master_rready,
    input  logic              io_master_rvalid,
    input  logic [1:0]        io_master_rresp,
    input  logic [63:0]       io_master_rdata,
    input  logic              io_master_rlast,
    input  logic [3:0]        io_master_rid,

    input  logic              io_master_awready,
    output logic              io_master_awvalid,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic [3:0]        io_master_awid,
    output logic [7:0]        io_master_awlen,
    output logic [2:0]        io_master_awsize,
    output logic [1:0]        io_master_awburst,

    input  logic              io_master_wready,
    output logic              io_master_wvalid,
    output logic [63:0]       io_master_wdata,
    output logic [7:0]        io_master_wstrb,
    output logic              io_master_wlast,

    output logic              io_master_bready,
    input  logic              io_master_bvalid,
    input  logic [1:0]        io_master_bresp,
    input  logic [3:0]        io_master_bid,

    output logic              err_o
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [3:0]        mask_q;
    logic [31:0]       data_q;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              ifu_prio_q, ifu_prio_d;

    logic              grant_fetch, grant_load, grant_store;
    logic              rd_done, wr_done;
    logic [31:0]       rword;

    // Response IDs are not checked with a single transaction in flight; upper mask bits are always zero.
    logic              unused_in;
    assign unused_in = ^{io_master_rid, io_master_bid, lsu_rstrb[7:4], lsu_wstrb[7:4]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction context captured at grant, plus handshake and fairness flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_IFU;
            addr_q     <= '0;
            size_q     <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ifu_prio_q <= 1'b0;
        end else begin
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            ifu_prio_q <= ifu_prio_d;
            if (grant_store) begin
                owner_q <= OWN_LSU;
                addr_q  <= lsu_awaddr;
                size_q  <= mask_to_size(lsu_wstrb[3:0]);
                mask_q  <= lsu_wstrb[3:0];
                data_q  <= 32'(lsu_wdata);
            end else if (grant_load) begin
                owner_q <= OWN_LSU;
                addr_q  <= lsu_araddr;
                size_q  <= mask_to_size(lsu_rstrb[3:0]);
                mask_q  <= lsu_rstrb[3:0];
                data_q  <= '0;
            end else if (grant_fetch) begin
                owner_q <= OWN_IFU;
                addr_q  <= ifu_araddr;
                size_q  <= AXI_SIZE_4B;
                mask_q  <= 4'hf;
                data_q  <= '0;
            end
        end
    end

    // Arbitration, next state and AXI handshake outputs.
    always_comb begin
        state_d           = state_q;
        grant_fetch       = 1'b0;
        grant_load        = 1'b0;
        grant_store       = 1'b0;
        aw_done_d         = aw_done_q;
        w_done_d          = w_done_q;
        ifu_prio_d        = ifu_prio_q;
        rd_done           = 1'b0;
        wr_done           = 1'b0;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (ifu_prio_q && ifu_arvalid) begin
                    grant_fetch = 1'b1;
                end else if (lsu_awvalid) begin
                    grant_store = 1'b1;
                end else if (lsu_arvalid) begin
                    grant_load = 1'b1;
                end else if (ifu_arvalid) begin
                    grant_fetch = 1'b1;
                end
                if (grant_store) begin
                    state_d = ST_AW_W;
                end else if (grant_load || grant_fetch) begin
                    state_d = ST_AR;
                end
                if (grant_store || grant_load || grant_fetch) begin
                    ifu_prio_d = 1'b0;
                end
            end
            ST_AR: begin
                io_master_arvalid = 1'b1;
                if (io_master_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                io_master_rready = 1'b1;
                if (io_master_rvalid && io_master_rlast) begin
                    rd_done = 1'b1;
                    state_d = ST_IDLE;
                    // A waiting fetch gets the next slot after any completed load.
                    if (owner_q == OWN_LSU) begin
                        ifu_prio_d = ifu_arvalid;
                    end
                end
            end
            ST_AW_W: begin
                io_master_awvalid = !aw_done_q;
                io_master_wvalid  = !w_done_q;
                aw_done_d = aw_done_q || io_master_awready;
                w_done_d  = w_done_q || io_master_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                io_master_bready = 1'b1;
                if (io_master_bvalid) begin
                    wr_done = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ysyx_axi_lane_align u_lane_align (
        .rdata   (io_master_rdata),
        .addr_lo (addr_q[2:0]),
        .word    (data_q),
        .mask    (mask_q),
        .rword   (rword),
        .wdata   (io_master_wdata),
        .wstrb   (io_master_wstrb)
    );

    assign io_master_araddr  = addr_q;
    assign io_master_arsize  = size_q;
    assign io_master_arid    = AXI_ID_ZERO;
    assign io_master_arlen   = AXI_LEN_SINGLE;
    assign io_master_arburst = AXI_BURST_INCR;

    assign io_master_awaddr  = addr_q;
    assign io_master_awsize  = size_q;
    assign io_master_awid    = AXI_ID_ZERO;
    assign io_master_awlen   = AXI_LEN_SINGLE;
    assign io_master_awburst = AXI_BURST_INCR;
    assign io_master_wlast   = io_master_wvalid;

    assign ifu_rvalid_o = rd_done && (owner_q == OWN_IFU);
    assign lsu_rvalid_o = rd_done && (owner_q == OWN_LSU);
    assign lsu_bvalid_o = wr_done;
    assign ifu_rdata_o  = ifu_rvalid_o ? DATA_W'(rword) : '0;
    assign lsu_rdata_o  = lsu_rvalid_o ? DATA_W'(rword) : '0;
    assign err_o        = (rd_done && (io_master_rresp != AXI_RESP_OKAY)) ||
                          (wr_done && (io_master_bresp != AXI_RESP_OKAY));

endmodule
